// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// A prescaler divides the system clock into a step tick. Each tick, or a
// manual STEP pulse, advances a WIDTH-bit LED pattern in one of four modes:
// up-count, down-count, walking-one or blink. LOAD overrides the pattern with
// a parallel value, and a mode change re-initialises the pattern.
module led_pattern_sequencer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 16777216
) (
    input  logic             OSC_50_B8A,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             STEP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] LED,
    output logic             TICK
);

    localparam int TW = $clog2(PRESCALE);
    localparam logic [TW-1:0]    RELOAD   = TW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_UP    = 2'd0,
        MODE_DOWN  = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] led_q, led_d;
    mode_t            mode_q, mode_d;
    logic             tick_q;
    logic             adv_tick;
    logic             adv;
    mode_t            mode_in;

    assign mode_in = mode_t'(MODE);

    // Pattern a mode starts from when it is selected.
    function automatic logic [WIDTH-1:0] init_pattern(input mode_t m);
        case (m)
            MODE_DOWN: init_pattern = '1;
            MODE_WALK: init_pattern = ONE_HOT0;
            default:   init_pattern = '0;
        endcase
    endfunction

    // One advance of the pattern; all arithmetic stays WIDTH bits wide.
    function automatic logic [WIDTH-1:0] next_pattern(input mode_t m,
                                                      input logic [WIDTH-1:0] v);
        case (m)
            MODE_UP:   next_pattern = v + WIDTH'(1);
            MODE_DOWN: next_pattern = v - WIDTH'(1);
            MODE_WALK: next_pattern = (v == '0) ? ONE_HOT0 : {v[WIDTH-2:0], v[WIDTH-1]};
            default:   next_pattern = ~v;
        endcase
    endfunction

    // Next-state logic: prescaler, advance event and LED update priority.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        timer_d  = timer_q;
        led_d    = led_q;
        mode_d   = mode_q;
        adv_tick = 1'b0;

        if (EN) begin
            if (timer_q == '0) begin
                timer_d  = RELOAD;
                adv_tick = 1'b1;
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end

        // A tick and a STEP in the same cycle merge into a single advance.
        adv = adv_tick | STEP;

        if (LOAD) begin
            // The mode is tracked but the loaded value is not overwritten.
            led_d  = LOAD_VAL;
            mode_d = mode_in;
        end else if (mode_in != mode_q) begin
            mode_d = mode_in;
            led_d  = init_pattern(mode_in);
        end else if (adv) begin
            led_d = next_pattern(mode_q, led_q);
        end
    end

    // State registers; reset is asynchronous and does not wait for a clock.
    always_ff @(posedge OSC_50_B8A or posedge RESET) begin
        if (RESET) begin
            timer_q <= RELOAD;
            led_q   <= '0;
            mode_q  <= MODE_UP;
            tick_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            timer_q <= timer_d;
            led_q   <= led_d;
            mode_q  <= mode_d;
            tick_q  <= adv_tick;
        end
    end

    assign LED  = led_q;
    assign TICK = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer with WIDTH=4, PRESCALE=4.
// Long counting runs use short loops; the walk/blink/load corners use a
// cycle-by-cycle vector table; async reset is a hand-written sequence.
module tb_led_pattern_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       step;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] led;
    logic       tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       step;
        logic       load;
        logic [3:0] load_val;
        logic [3:0] exp_led;
        logic       exp_tick;
    } vec_t;

    vec_t vecs[$];

    led_pattern_sequencer #(
        .WIDTH   (4),
        .PRESCALE(4)
    ) dut (
        .OSC_50_B8A(clk),
        .RESET     (rst),
        .EN        (en),
        .MODE      (mode),
        .STEP      (step),
        .LOAD      (load),
        .LOAD_VAL  (load_val),
        .LED       (led),
        .TICK      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic clk_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string name, input logic [3:0] e_led, input logic e_tick);
        clk_cycle();
        check($sformatf("%s led", name), 32'(led), 32'(e_led));
        check($sformatf("%s tick", name), 32'(tick), 32'(e_tick));
    endtask

    task automatic add(input logic e, input logic [1:0] m, input logic s, input logic l,
                       input logic [3:0] lv, input logic [3:0] el, input logic et);
        vecs.push_back('{e, m, s, l, lv, el, et});
    endtask

    initial begin
        logic [3:0] exp_led;

        // Walking-one from down mode, then a non-one-hot load.
        add(1, 2, 0, 0, 4'h0, 4'h1, 0);
        add(1, 2, 0, 0, 4'h0, 4'h1, 0);
        add(1, 2, 0, 0, 4'h0, 4'h1, 0);
        add(1, 2, 0, 0, 4'h0, 4'h2, 1);
        for (int i = 0; i < 3; i++) add(1, 2, 0, 0, 4'h0, 4'h2, 0);
        add(1, 2, 0, 0, 4'h0, 4'h4, 1);
        for (int i = 0; i < 3; i++) add(1, 2, 0, 0, 4'h0, 4'h4, 0);
        add(1, 2, 0, 0, 4'h0, 4'h8, 1);
        for (int i = 0; i < 3; i++) add(1, 2, 0, 0, 4'h0, 4'h8, 0);
        add(1, 2, 0, 0, 4'h0, 4'h1, 1);
        add(1, 2, 0, 1, 4'h5, 4'h5, 0);
        add(1, 2, 0, 0, 4'h5, 4'h5, 0);
        add(1, 2, 0, 0, 4'h5, 4'h5, 0);
        add(1, 2, 0, 0, 4'h5, 4'hA, 1);
        for (int i = 0; i < 3; i++) add(1, 2, 0, 0, 4'h5, 4'hA, 0);
        add(1, 2, 0, 0, 4'h5, 4'h5, 1);
        // Blink with EN=0 and manual steps; timer frozen; STEP merged with tick.
        add(0, 3, 0, 0, 4'h0, 4'h0, 0);
        add(0, 3, 1, 0, 4'h0, 4'hF, 0);
        add(0, 3, 0, 0, 4'h0, 4'hF, 0);
        add(0, 3, 1, 0, 4'h0, 4'h0, 0);
        add(0, 3, 1, 0, 4'h0, 4'hF, 0);
        for (int i = 0; i < 3; i++) add(1, 3, 0, 0, 4'h0, 4'hF, 0);
        add(1, 3, 1, 0, 4'h0, 4'h0, 1);
        // LOAD coincident with a tick in up mode.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 4'h0, 4'h0, 0);
        add(1, 0, 0, 1, 4'h9, 4'h9, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 4'h9, 4'h9, 0);
        add(1, 0, 0, 0, 4'h9, 4'hA, 1);

        rst      = 1'b1;
        en       = 1'b0;
        mode     = 2'd0;
        step     = 1'b0;
        load     = 1'b0;
        load_val = 4'h0;

        // Reset state.
        clk_cycle();
        clk_cycle();
        check("reset led", 32'(led), 32'h0);
        check("reset tick", 32'(tick), 32'h0);
        rst = 1'b0;
        en  = 1'b1;

        // Up-count through a full wrap: tick every 4th cycle.
        for (int k = 1; k <= 16; k++) begin
            for (int j = 0; j < 3; j++) expect_cycle($sformatf("up%0d.%0d", k, j), 4'(k - 1), 1'b0);
            expect_cycle($sformatf("up%0d", k), 4'(k), 1'b1);
        end

        // Count to 5, then switch to down on a tick cycle: advance is dropped.
        for (int k = 1; k <= 5; k++) begin
            for (int j = 0; j < 3; j++) clk_cycle();
            expect_cycle($sformatf("up5_%0d", k), 4'(k), 1'b1);
        end
        for (int j = 0; j < 3; j++) expect_cycle("pre_mode", 4'h5, 1'b0);
        mode = 2'd1;
        expect_cycle("mode_to_down", 4'hF, 1'b1);
        exp_led = 4'hF;
        for (int k = 1; k <= 16; k++) begin
            for (int j = 0; j < 3; j++) expect_cycle($sformatf("dn%0d.%0d", k, j), exp_led, 1'b0);
            exp_led = exp_led - 4'h1;
            expect_cycle($sformatf("dn%0d", k), exp_led, 1'b1);
        end

        // Table-driven corner cases.
        for (int i = 0; i < vecs.size(); i++) begin
            en       = vecs[i].en;
            mode     = vecs[i].mode;
            step     = vecs[i].step;
            load     = vecs[i].load;
            load_val = vecs[i].load_val;
            expect_cycle($sformatf("vec%0d", i), vecs[i].exp_led, vecs[i].exp_tick);
        end
        step = 1'b0;
        load = 1'b0;

        // Asynchronous reset between edges, right after a tick (LED=A, TICK=1).
        rst = 1'b1;
        #2;
        check("async led", 32'(led), 32'h0);
        check("async tick", 32'(tick), 32'h0);
        clk_cycle();
        clk_cycle();
        rst  = 1'b0;
        en   = 1'b1;
        mode = 2'd0;
        for (int j = 0; j < 3; j++) expect_cycle($sformatf("post_rst%0d", j), 4'h0, 1'b0);
        expect_cycle("post_rst_tick", 4'h1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
